// File: rtl/lifo.sv
`default_nettype none
// ============================================================================
// Module      : lifo
// Description : Single-clock last-in/first-out stack of LIFO_SIZE words.
//               Pops are delivered on a registered output with a one-cycle
//               valid strobe; a simultaneous read and write replaces the top
//               entry while returning the old top.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo #(
    parameter int DATA_W    = 5,
    parameter int LIFO_SIZE = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              val,
    output logic              full
);

    // Occupancy needs to represent 0..LIFO_SIZE inclusive.
    localparam int CNT_W = $clog2(LIFO_SIZE + 1);
    // Storage index width; a one-entry stack still needs a 1-bit index.
    localparam int IDX_W = (LIFO_SIZE > 1) ? $clog2(LIFO_SIZE) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LIFO_SIZE);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [DATA_W-1:0] mem [LIFO_SIZE];
    logic [CNT_W-1:0]  count;

    logic              empty;
    logic              do_pop;
    logic              do_swap;
    logic              do_push;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;

    // full is a pure decode of the registered occupancy, so it changes on the
    // same edge that changes count.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Decode the request into exactly one of pop, swap (pop+push) or push.
    // A write on an empty stack with read also asserted degenerates to a
    // plain push because there is nothing to return.
    always_comb begin
        do_pop  = 1'b0;
        do_swap = 1'b0;
        do_push = 1'b0;
        top_idx = IDX_W'(count - ONE_CNT);
        wr_idx  = IDX_W'(count);
        if (read && !empty) begin
            do_pop  = 1'b1;
            do_swap = write;
        end else if (write && !full) begin
            do_push = 1'b1;
        end
    end

    // Stack storage, occupancy and registered pop output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            dataout <= '0;
            val     <= 1'b0;
            for (int i = 0; i < LIFO_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else begin
            val <= do_pop;
            if (do_pop) begin
                dataout <= mem[top_idx];
            end
            if (do_swap) begin
                // Old top has just been captured into dataout; overwrite it in place.
                mem[top_idx] <= datain;
            end else if (do_pop) begin
                count <= count - ONE_CNT;
            end else if (do_push) begin
                mem[wr_idx] <= datain;
                count       <= count + ONE_CNT;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifo
// Description : Directed, scoreboard-based bench for the lifo stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo;

    localparam int DATA_W    = 5;
    localparam int LIFO_SIZE = 2;

    logic              clock;
    logic              reset;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] dataout;
    logic              val;
    logic              full;

    int checks   = 0;
    int failures = 0;

    // Reference stack contents and last popped word.
    logic [DATA_W-1:0] stk [$];
    logic [DATA_W-1:0] mdout;

    // Expected {val, dataout, full} per step, consumed after the edge.
    logic [DATA_W+1:0] exp_q [$];

    lifo #(
        .DATA_W    (DATA_W),
        .LIFO_SIZE (LIFO_SIZE)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .write   (write),
        .read    (read),
        .datain  (datain),
        .dataout (dataout),
        .val     (val),
        .full    (full)
    );

    // 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: update the reference model, queue the expected
    // outputs, clock the DUT and compare against the scoreboard head.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [DATA_W-1:0] d);
        logic              e_val;
        logic [DATA_W-1:0] e_dout;
        logic [DATA_W+1:0] e;
        e_val  = 1'b0;
        e_dout = mdout;
        if (r && stk.size() > 0) begin
            e_dout = stk[stk.size()-1];
            e_val  = 1'b1;
            if (w) stk[stk.size()-1] = d;
            else   void'(stk.pop_back());
        end else if (w && stk.size() < LIFO_SIZE) begin
            stk.push_back(d);
        end
        mdout = e_dout;
        exp_q.push_back({e_val, e_dout, (stk.size() == LIFO_SIZE)});

        write  = w;
        read   = r;
        datain = d;
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check({tag, ".val"},     DATA_W'(val),  DATA_W'(e[DATA_W+1]));
        check({tag, ".dataout"}, dataout,       e[DATA_W:1]);
        check({tag, ".full"},    DATA_W'(full), DATA_W'(e[0]));
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        write  = 1'b0;
        read   = 1'b0;
        datain = '0;
        mdout  = '0;

        // Reset held low while a push is requested: everything stays clear.
        #2;
        reset  = 1'b0;
        write  = 1'b1;
        datain = 5'b11111;
        #1;
        check("rst_async.dataout", dataout, 5'b00000);
        check("rst_async.val", DATA_W'(val), 5'd0);
        check("rst_async.full", DATA_W'(full), 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("rst_hold.dataout", dataout, 5'b00000);
            check("rst_hold.val", DATA_W'(val), 5'd0);
            check("rst_hold.full", DATA_W'(full), 5'd0);
        end
        write  = 1'b0;
        datain = '0;
        reset  = 1'b1;

        step("idle_after_rst", 1'b0, 1'b0, 5'b00000);
        step("underflow0",     1'b0, 1'b1, 5'b00000);

        // Fill and overflow.
        step("push1",          1'b1, 1'b0, 5'b10011);
        step("push2",          1'b1, 1'b0, 5'b11001);
        step("push_ovf",       1'b1, 1'b0, 5'b00111);

        // Pop order.
        step("pop1",           1'b0, 1'b1, 5'b00000);
        step("idle_hold",      1'b0, 1'b0, 5'b00000);
        step("pop2",           1'b0, 1'b1, 5'b00000);
        step("underflow1",     1'b0, 1'b1, 5'b00000);

        // Simultaneous read/write with one entry, held four cycles.
        step("push_one",       1'b1, 1'b0, 5'b10011);
        for (int i = 0; i < 4; i++) begin
            step("swap_one",   1'b1, 1'b1, 5'b10000);
        end
        step("pop_after_swap", 1'b0, 1'b1, 5'b00000);

        // Simultaneous read/write while full.
        step("fill_a",         1'b1, 1'b0, 5'b10011);
        step("fill_b",         1'b1, 1'b0, 5'b11001);
        step("swap_full",      1'b1, 1'b1, 5'b00001);
        step("pop_new_top",    1'b0, 1'b1, 5'b00000);
        step("pop_bottom",     1'b0, 1'b1, 5'b00000);

        // Simultaneous read/write while empty acts as a push.
        step("swap_empty",     1'b1, 1'b1, 5'b01010);
        step("pop_swapped",    1'b0, 1'b1, 5'b00000);

        // Asynchronous reset mid-operation discards contents.
        step("refill_a",       1'b1, 1'b0, 5'b00110);
        step("refill_b",       1'b1, 1'b0, 5'b01100);
        step("pop_before_rst", 1'b0, 1'b1, 5'b00000);
        step("refill_c",       1'b1, 1'b0, 5'b11100);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid.dataout", dataout, 5'b00000);
        check("rst_mid.val", DATA_W'(val), 5'd0);
        check("rst_mid.full", DATA_W'(full), 5'd0);
        #1;
        reset = 1'b1;
        stk.delete();
        mdout = '0;
        @(posedge clock);
        #1;
        step("pop_after_rst",  1'b0, 1'b1, 5'b00000);
        step("push_after_rst", 1'b1, 1'b0, 5'b00101);
        step("pop_fresh",      1'b0, 1'b1, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
